moxie_bus_arbiter: RTL and testbench

Shares the core's single 32-bit Wishbone master port between two requesters: the instruction fetch stage and the data load/store path. Registered, non-pipelined, one transaction at a time, with a per-transaction timeout. Sits between the pipeline stages and the external bus, and replaces the fetch stage's direct drive of the bus address.

---
 rtl/moxie_bus_pkg.sv | 28 ++
 rtl/moxie_bus_timeout.sv | 45 ++++
 rtl/moxie_bus_arbiter.sv | 170 +++++++++++++++++
 tb/tb_moxie_bus_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/moxie_bus_pkg.sv
// ============================================================================
// Module      : moxie_bus_pkg
// Description : Shared arbiter state encoding, fetch byte-select and default
//               timeout for the moxie core bus logic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package moxie_bus_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GNT_I = 2'd1,
        ARB_GNT_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_e;

    localparam logic [3:0]  SEL_WORD        = 4'hF;
    localparam int unsigned DEFAULT_TIMEOUT = 255;
    localparam int unsigned DEFAULT_CNT_W   = 8;

endpackage

`default_nettype wire

// File: rtl/moxie_bus_timeout.sv
// ============================================================================
// Module      : moxie_bus_timeout
// Description : Saturating wait counter compared against a limit input;
//               a zero limit never expires.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module moxie_bus_timeout #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             expired_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Saturate rather than wrap so a disabled timeout can never alias to a hit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (limit_i != '0) && (cnt_q == limit_i);

endmodule

`default_nettype wire

// File: rtl/moxie_bus_arbiter.sv
// ============================================================================
// Module      : moxie_bus_arbiter
// Description : Two-requester (fetch / data) Wishbone master arbiter with a
//               per-transaction timeout. Define MOXIE_ARB_RR_EN for
//               round-robin arbitration instead of fixed data priority.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module moxie_bus_arbiter
    import moxie_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
    parameter int unsigned CNT_W          = DEFAULT_CNT_W
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_req_i,
    input  logic [31:0] if_adr_i,
    output logic [31:0] if_dat_o,
    output logic        if_ack_o,
    output logic        if_err_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [3:0]  d_sel_i,
    input  logic [31:0] d_adr_i,
    input  logic [31:0] d_dat_i,
    output logic [31:0] d_dat_o,
    output logic        d_ack_o,
    output logic        d_err_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    output logic        busy_o
);

    localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT_CYCLES);

    arb_state_e  state_q, state_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] wdat_q, wdat_d;
    logic        gnt_i, gnt_d;
    logic        pick_d;
    logic        in_gnt;
    logic        own_i, own_d;
    logic        expired;

`ifdef MOXIE_ARB_RR_EN
    grant_e last_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            last_q <= GRANT_I;
        end else if (gnt_d) begin
            last_q <= GRANT_D;
        end else if (gnt_i) begin
            last_q <= GRANT_I;
        end
    end

    assign pick_d = d_req_i && (!if_req_i || (last_q == GRANT_I));
`else
    assign pick_d = d_req_i;
`endif

    assign own_i  = (state_q == ARB_GNT_I);
    assign own_d  = (state_q == ARB_GNT_D);
    assign in_gnt = own_i || own_d;

    moxie_bus_timeout #(
        .CNT_W     (CNT_W)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (!in_gnt),
        .en_i      (in_gnt),
        .limit_i   (c_timeout),
        .expired_o (expired)
    );

    always_comb begin
        state_d = state_q;
        gnt_i   = 1'b0;
        gnt_d   = 1'b0;
        cyc_d   = cyc_q;
        we_d    = we_q;
        sel_d   = sel_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;

        case (state_q)
            ARB_IDLE: begin
                if (pick_d) begin
                    state_d = ARB_GNT_D;
                    gnt_d   = 1'b1;
                end else if (if_req_i) begin
                    state_d = ARB_GNT_I;
                    gnt_i   = 1'b1;
                end
            end
            ARB_GNT_I, ARB_GNT_D: begin
                // Ack takes precedence over a coinciding timeout; both end the cycle.
                if (wb_ack_i || expired) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        if (gnt_d) begin
            cyc_d  = 1'b1;
            we_d   = d_we_i;
            sel_d  = d_sel_i;
            adr_d  = d_adr_i;
            wdat_d = d_dat_i;
        end else if (gnt_i) begin
            cyc_d  = 1'b1;
            we_d   = 1'b0;
            sel_d  = SEL_WORD;
            adr_d  = if_adr_i;
            wdat_d = '0;
        end else if (state_d == ARB_IDLE) begin
            cyc_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ARB_IDLE;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            wdat_q  <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
        end
    end

    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;
    assign wb_we_o  = we_q;
    assign wb_sel_o = sel_q;
    assign wb_adr_o = adr_q;
    assign wb_dat_o = wdat_q;
    assign busy_o   = (state_q != ARB_IDLE);

    assign if_ack_o = own_i && wb_ack_i;
    assign d_ack_o  = own_d && wb_ack_i;
    assign if_err_o = own_i && expired && !wb_ack_i;
    assign d_err_o  = own_d && expired && !wb_ack_i;
    assign if_dat_o = own_i ? wb_dat_i : '0;
    assign d_dat_o  = own_d ? wb_dat_i : '0;

endmodule

`default_nettype wire

// File: tb/tb_moxie_bus_arbiter.sv
// ============================================================================
// Module      : tb_moxie_bus_arbiter
// Description : Randomized self-checking bench for moxie_bus_arbiter against a
//               cycle-level transaction model (honours MOXIE_ARB_RR_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_moxie_bus_arbiter;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_adr;
    logic [31:0] if_dat;
    logic        if_ack, if_err;
    logic        d_req, d_we;
    logic [3:0]  d_sel;
    logic [31:0] d_adr, d_wdat, d_rdat;
    logic        d_ack, d_err;
    logic        wb_cyc, wb_stb, wb_we;
    logic [3:0]  wb_sel;
    logic [31:0] wb_adr, wb_wdat, wb_rdat;
    logic        wb_ack;
    logic        busy;

    always #5 clk = ~clk;

    moxie_bus_arbiter #(
        .TIMEOUT_CYCLES (T),
        .CNT_W          (8)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst_n),
        .if_req_i (if_req),
        .if_adr_i (if_adr),
        .if_dat_o (if_dat),
        .if_ack_o (if_ack),
        .if_err_o (if_err),
        .d_req_i  (d_req),
        .d_we_i   (d_we),
        .d_sel_i  (d_sel),
        .d_adr_i  (d_adr),
        .d_dat_i  (d_wdat),
        .d_dat_o  (d_rdat),
        .d_ack_o  (d_ack),
        .d_err_o  (d_err),
        .wb_cyc_o (wb_cyc),
        .wb_stb_o (wb_stb),
        .wb_we_o  (wb_we),
        .wb_sel_o (wb_sel),
        .wb_adr_o (wb_adr),
        .wb_dat_o (wb_wdat),
        .wb_dat_i (wb_rdat),
        .wb_ack_i (wb_ack),
        .busy_o   (busy)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: owner 0 = none, 1 = fetch, 2 = data; wait = cycles since grant edge.
    int          m_owner = 0;
    int          m_wait  = 0;
    int          m_last  = 1;
    int          m_lat   = 0;
    logic [31:0] m_adr, m_wdat;
    logic        m_we;
    logic [3:0]  m_sel;
    bit          i_done = 0;
    bit          d_done = 0;
    int          force_lat = -1;
    int          obs_if_ack = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle();
        bit gi, gd, tmo;
        int w;
        #1;
        gi  = (m_owner == 1);
        gd  = (m_owner == 2);
        tmo = (m_wait == T) && !wb_ack;
        check("busy",   32'(busy),   32'(m_owner != 0));
        check("cyc",    32'(wb_cyc), 32'(m_owner != 0));
        check("stb",    32'(wb_stb), 32'(m_owner != 0));
        check("if_ack", 32'(if_ack), 32'(gi && wb_ack));
        check("d_ack",  32'(d_ack),  32'(gd && wb_ack));
        check("if_err", 32'(if_err), 32'(gi && tmo));
        check("d_err",  32'(d_err),  32'(gd && tmo));
        check("if_dat", if_dat, gi ? wb_rdat : 32'h0);
        check("d_dat",  d_rdat, gd ? wb_rdat : 32'h0);
        if (m_owner != 0) begin
            check("adr", wb_adr, m_adr);
            check("we",  32'(wb_we), 32'(m_we));
            check("sel", 32'(wb_sel), 32'(m_sel));
            if (gd) check("wdat", wb_wdat, m_wdat);
        end
        if (if_ack) obs_if_ack++;
        i_done = gi && (wb_ack || m_wait == T);
        d_done = gd && (wb_ack || m_wait == T);
        @(posedge clk);
        if (!rst_n) begin
            m_owner = 0; m_wait = 0; m_last = 1;
            i_done = 1; d_done = 1;
        end else if (m_owner != 0) begin
            if (wb_ack || m_wait == T) m_owner = 0;
            else m_wait++;
        end else begin
            w = 0;
            if (d_req && if_req) begin
`ifdef MOXIE_ARB_RR_EN
                w = (m_last == 2) ? 1 : 2;
`else
                w = 2;
`endif
            end else if (d_req) w = 2;
            else if (if_req) w = 1;
            if (w != 0) begin
                m_owner = w; m_wait = 0; m_last = w;
                m_lat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 6));
                if (w == 1) begin
                    m_adr = if_adr; m_we = 1'b0; m_sel = 4'hF; m_wdat = 32'h0;
                end else begin
                    m_adr = d_adr; m_we = d_we; m_sel = d_sel; m_wdat = d_wdat;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic drop_done();
        if (i_done) begin if_req = 1'b0; i_done = 0; end
        if (d_done) begin d_req  = 1'b0; d_done = 0; end
    endtask

    task automatic run_directed(input int n, input logic [31:0] rdata);
        for (int k = 0; k < n; k++) begin
            drop_done();
            rst_n   = 1'b1;
            wb_ack  = (m_owner != 0) && (m_wait == m_lat);
            wb_rdat = rdata;
            cycle();
        end
    endtask

    task automatic drive(input int p_i, input int p_d, input int p_rst);
        drop_done();
        if (!if_req && (int'($urandom_range(0, 99)) < p_i)) begin
            if_req = 1'b1;
            if_adr = $urandom & ~32'h3;
        end
        if (!d_req && (int'($urandom_range(0, 99)) < p_d)) begin
            d_req  = 1'b1;
            d_we   = 1'($urandom);
            d_sel  = 4'($urandom);
            d_adr  = $urandom;
            d_wdat = $urandom;
        end
        if (m_owner != 0) wb_ack = (m_wait == m_lat);
        else              wb_ack = ($urandom_range(0, 7) == 0);
        wb_rdat = $urandom;
        rst_n   = !(int'($urandom_range(0, 99)) < p_rst);
        if (!rst_n) wb_ack = 1'b0;
        cycle();
    endtask

    initial begin
        rst_n = 1'b0; if_req = 1'b0; if_adr = '0;
        d_req = 1'b0; d_we = 1'b0; d_sel = '0; d_adr = '0; d_wdat = '0;
        wb_ack = 1'b0; wb_rdat = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_adr",  wb_adr,          32'h0);
        check("rst_sel",  32'(wb_sel),     32'h0);
        check("rst_we",   32'(wb_we),      32'h0);
        check("rst_wdat", wb_wdat,         32'h0);
        check("rst_busy", 32'(busy),       32'h0);
        check("rst_cyc",  32'(wb_cyc),     32'h0);
        @(negedge clk);

        // Single fetch, slave acks 3 cycles after strobe.
        force_lat = 3; obs_if_ack = 0;
        if_req = 1'b1; if_adr = 32'h1000;
        run_directed(8, 32'hDEADBEEF);
        check("fetch_ack_pulses", 32'(obs_if_ack), 32'd1);

        // Simultaneous requests.
        force_lat = 1;
        if_req = 1'b1; if_adr = 32'h3000;
        d_req = 1'b1; d_we = 1'b1; d_sel = 4'h3; d_adr = 32'h2000; d_wdat = 32'h12345678;
        run_directed(10, 32'hCAFE0001);

        // Data timeout, then ack on the expiry cycle.
        force_lat = 99;
        d_req = 1'b1; d_we = 1'b0; d_sel = 4'hF; d_adr = 32'h4000;
        run_directed(8, 32'h0);
        force_lat = T;
        d_req = 1'b1; d_adr = 32'h4004;
        run_directed(8, 32'hA5A5A5A5);

        // Reset mid-fetch, then a late ack must be ignored.
        force_lat = 99;
        if_req = 1'b1; if_adr = 32'h5000;
        run_directed(3, 32'h0);
        rst_n = 1'b0; wb_ack = 1'b0;
        cycle();
        drop_done();
        rst_n = 1'b1; wb_ack = 1'b1;
        cycle();
        wb_ack = 1'b0;
        cycle();

        // Both requesters saturated: fixed priority starves fetch, RR alternates.
        force_lat = -1;
        for (int k = 0; k < 40; k++) drive(100, 100, 0);
        for (int k = 0; k < 10; k++) drive(0, 0, 0);

        for (int k = 0; k < 3000; k++) drive(30, 30, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
